// File: rtl/aes_req_arbiter.sv
// Two-port arbiter sharing one pipelined AES-128 core; a tag pipeline tracks each job's owner
// so the ciphertext is routed back to the requester that issued it. Optional: AES_ARB_STRICT_PRIO_EN.
module aes_req_arbiter #(
    parameter int LATENCY = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_state,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_state,
    input  logic [127:0] req1_key,
    input  logic         hold,
    output logic         core_valid,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [127:0] rsp_data,
    output logic [7:0]   inflight
);

    logic               grant0_s;
    logic               grant1_s;
    logic               xfer_s;
    logic               tag_exit_s;
    logic               core_valid_r;
    logic               core_id_r;
    logic [127:0]       core_state_r;
    logic [127:0]       core_key_r;
    logic [LATENCY-1:0] tag_v_r;
    logic [LATENCY-1:0] tag_id_r;
    logic               rsp0_valid_r;
    logic               rsp1_valid_r;
    logic [127:0]       rsp_data_r;
    logic [7:0]         inflight_r;
`ifndef AES_ARB_STRICT_PRIO_EN
    logic               last_r;
`endif

    // Grant selection: hold blocks everything, otherwise priority or round-robin
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (hold) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
`ifdef AES_ARB_STRICT_PRIO_EN
            grant0_s = req0_valid;
            grant1_s = req1_valid & ~req0_valid;
`else
            // With both valid, the requester that did not win last time goes next
            grant0_s = req0_valid & (~req1_valid | last_r);
            grant1_s = req1_valid & (~req0_valid | ~last_r);
`endif
        end
    end

    assign xfer_s     = grant0_s | grant1_s;
    assign tag_exit_s = tag_v_r[LATENCY-1];

`ifndef AES_ARB_STRICT_PRIO_EN
    // Round-robin history, starts as 1 so requester 0 wins the first contest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (xfer_s) begin
            last_r <= grant1_s;
        end
    end
`endif

    // Core issue register; data holds when idle so the core inputs do not toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid_r <= 1'b0;
            core_id_r    <= 1'b0;
            core_state_r <= 128'd0;
            core_key_r   <= 128'd0;
        end else begin
            core_valid_r <= xfer_s;
            core_id_r    <= grant1_s;
            if (xfer_s) begin
                core_state_r <= grant1_s ? req1_state : req0_state;
                core_key_r   <= grant1_s ? req1_key   : req0_key;
            end
        end
    end

    // Owner tags; the last stage lines up with the cycle core_out holds that job's result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_r  <= '0;
            tag_id_r <= '0;
        end else begin
            tag_v_r  <= (tag_v_r << 1)  | LATENCY'(core_valid_r);
            tag_id_r <= (tag_id_r << 1) | LATENCY'(core_id_r);
        end
    end

    // Response capture and routing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_data_r   <= 128'd0;
        end else begin
            rsp0_valid_r <= tag_exit_s & ~tag_id_r[LATENCY-1];
            rsp1_valid_r <= tag_exit_s &  tag_id_r[LATENCY-1];
            if (tag_exit_s) begin
                rsp_data_r <= core_out;
            end
        end
    end

    // Outstanding job count: bounded by LATENCY+2, so 8 bits cannot wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= 8'd0;
        end else begin
            inflight_r <= inflight_r + {7'd0, xfer_s} - {7'd0, rsp0_valid_r | rsp1_valid_r};
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign core_valid = core_valid_r;
    assign core_state = core_state_r;
    assign core_key   = core_key_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp_data   = rsp_data_r;
    assign inflight   = inflight_r;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: behavioural AES-128 core of latency LAT plus a scoreboard model
// of arbitration, response timing and inflight count; directed scenarios and a random run.
module tb_aes_req_arbiter;

    localparam int LAT = 21;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready, hold;
    logic [127:0] req0_state, req0_key, req1_state, req1_key;
    logic         core_valid;
    logic [127:0] core_state, core_key, core_out;
    logic         rsp0_valid, rsp1_valid;
    logic [127:0] rsp_data;
    logic [7:0]   inflight;

    int n_vec = 0;
    int n_err = 0;

    aes_req_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_state(req0_state), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_state(req1_state), .req1_key(req1_key),
        .hold(hold), .core_valid(core_valid), .core_state(core_state), .core_key(core_key),
        .core_out(core_out), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES-128 reference ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    initial begin
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv, r, p;
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(b));
            if (b == 0) inv = 8'h00;
            r = inv; p = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                p = p ^ r;
            end
            sb[b] = p ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [7:0] tmp [4];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tmp[0] = sb[w[i-3]] ^ rc;
                tmp[1] = sb[w[i-2]];
                tmp[2] = sb[w[i-1]];
                tmp[3] = sb[w[i-4]];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    t[c*4+rw] = sb[s[((c+rw)%4)*4+rw]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
                if (r < 10) begin
                    s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[c*4] = a0; s[c*4+1] = a1; s[c*4+2] = a2; s[c*4+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural core: result of the inputs presented in cycle t appears in cycle t+LAT
    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= core_valid ? aes_enc(core_state, core_key) : rnd128();
    end
    assign core_out = pipe[LAT-1];

    // ---------------- scoreboard model ----------------
    typedef struct packed {
        logic         id;
        logic [127:0] data;
        int           due;
    } rsp_t;

    rsp_t         sb_q [$];
    int           cyc = 0;
    logic         m_last = 1'b1;
    int           m_inflight = 0;
    logic [127:0] m_data = '0, m_cs = '0, m_ck = '0;
    logic         m_cv = 1'b0;

    always @(negedge clk) begin
        logic eg0, eg1, e_r0, e_r1;
        rsp_t e;
        cyc++;
        if (rst) begin
            sb_q.delete();
            m_last = 1'b1; m_inflight = 0; m_data = '0; m_cs = '0; m_ck = '0; m_cv = 1'b0;
            n_vec++;
            if ({rsp0_valid, rsp1_valid, core_valid} !== 3'b000 || inflight !== 8'd0) begin
                n_err++;
                $display("FAIL mon_reset cyc=%0d got rsp=%b%b cv=%b infl=%0d want all 0",
                         cyc, rsp0_valid, rsp1_valid, core_valid, inflight);
            end
        end else begin
            // Expected winner: nobody under hold; the sole requester; or the one not granted last
            eg0 = 1'b0; eg1 = 1'b0;
            if (!hold) begin
                if (req0_valid && req1_valid) begin
`ifdef AES_ARB_STRICT_PRIO_EN
                    eg0 = 1'b1;
`else
                    eg0 = m_last; eg1 = !m_last;
`endif
                end else begin
                    eg0 = req0_valid; eg1 = req1_valid;
                end
            end
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                e_r0 = !e.id; e_r1 = e.id; m_data = e.data;
            end
            n_vec++;
            if ({req0_ready, req1_ready} !== {eg0, eg1}) begin
                n_err++;
                $display("FAIL mon_grant cyc=%0d got %b%b want %b%b", cyc, req0_ready, req1_ready, eg0, eg1);
            end
            n_vec++;
            if ({rsp0_valid, rsp1_valid} !== {e_r0, e_r1} || rsp_data !== m_data) begin
                n_err++;
                $display("FAIL mon_rsp cyc=%0d got %b%b %h want %b%b %h",
                         cyc, rsp0_valid, rsp1_valid, rsp_data, e_r0, e_r1, m_data);
            end
            n_vec++;
            if (inflight !== 8'(m_inflight) || core_valid !== m_cv || core_state !== m_cs || core_key !== m_ck) begin
                n_err++;
                $display("FAIL mon_core cyc=%0d got infl=%0d cv=%b st=%h want infl=%0d cv=%b st=%h",
                         cyc, inflight, core_valid, core_state, m_inflight, m_cv, m_cs);
            end
            if (e_r0 || e_r1) m_inflight--;
            m_cv = eg0 || eg1;
            if (eg0 || eg1) begin
                m_cs = eg1 ? req1_state : req0_state;
                m_ck = eg1 ? req1_key : req0_key;
                e.id = eg1; e.data = aes_enc(m_cs, m_ck); e.due = cyc + LAT + 2;
                sb_q.push_back(e);
                m_inflight++;
                m_last = eg1;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (core_valid !== 1'b0 || core_state !== 128'd0 || core_key !== 128'd0 || rsp0_valid !== 1'b0 ||
            rsp1_valid !== 1'b0 || rsp_data !== 128'd0 || inflight !== 8'd0) begin
            n_err++;
            $display("FAIL reset_values got cv=%b st=%h key=%h rsp=%b%b data=%h infl=%0d want zeros",
                     core_valid, core_state, core_key, rsp0_valid, rsp1_valid, rsp_data, inflight);
        end
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_state = rnd128(); req0_key = rnd128(); req1_state = rnd128(); req1_key = rnd128();
        @(negedge clk);
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_first_grant got %b%b want 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single_job();
        logic [127:0] kat;
        kat = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk); #1;
            req0_valid = (k == 0);
            req0_key   = 128'h000102030405060708090a0b0c0d0e0f;
            req0_state = 128'h00112233445566778899aabbccddeeff;
            @(negedge clk);
            n_vec++;
            if (rsp0_valid !== (k == LAT + 2) || rsp1_valid !== 1'b0 ||
                inflight !== ((k >= 1 && k <= LAT + 2) ? 8'd1 : 8'd0)) begin
                n_err++;
                $display("FAIL single_timing k=%0d got rsp=%b%b infl=%0d", k, rsp0_valid, rsp1_valid, inflight);
            end
            if (k == LAT + 2) begin
                n_vec++;
                if (rsp_data !== kat) begin
                    n_err++;
                    $display("FAIL single_data got %h want %h", rsp_data, kat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp0, exp1;
        int   ids [$];
        int   first_k, max_inf;
        first_k = -1; max_inf = 0;
        do_reset();
        for (int k = 0; k < 36; k++) begin
            @(posedge clk); #1;
            req0_valid = (k < 8); req1_valid = (k < 8);
            req0_state = rnd128(); req0_key = rnd128(); req1_state = rnd128(); req1_key = rnd128();
            @(negedge clk);
            if (k < 8) begin
                exp0 = 1'b1; exp1 = 1'b0;
`ifndef AES_ARB_STRICT_PRIO_EN
                exp0 = (k % 2 == 0); exp1 = !exp0;
`endif
                n_vec++;
                if (req0_ready !== exp0 || req1_ready !== exp1) begin
                    n_err++;
                    $display("FAIL b2b_grant k=%0d got %b%b want %b%b", k, req0_ready, req1_ready, exp0, exp1);
                end
            end
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            if (rsp0_valid || rsp1_valid) begin
                if (first_k < 0) first_k = k;
                ids.push_back(rsp1_valid ? 1 : 0);
            end
        end
        n_vec++;
        if (max_inf != 8 || first_k != LAT + 2 || ids.size() != 8) begin
            n_err++;
            $display("FAIL b2b_drain got max_inflight=%0d first=%0d count=%0d want 8 %0d 8",
                     max_inf, first_k, ids.size(), LAT + 2);
        end
        for (int i = 0; i < ids.size(); i++) begin
            n_vec++;
`ifdef AES_ARB_STRICT_PRIO_EN
            if (ids[i] != 0) begin
`else
            if (ids[i] != i % 2) begin
`endif
                n_err++;
                $display("FAIL b2b_order idx=%0d got id %0d", i, ids[i]);
            end
        end
    endtask

    task automatic test_hold();
        int pulses [$];
        do_reset();
        for (int k = 0; k < 36; k++) begin
            @(posedge clk); #1;
            hold = (k >= 2 && k < 7);
            req0_valid = (k < 7); req1_valid = (k < 7);
            req0_state = rnd128(); req0_key = rnd128(); req1_state = rnd128(); req1_key = rnd128();
            @(negedge clk);
            if (k >= 2 && k < 7) begin
                n_vec++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_ready k=%0d got %b%b want 00", k, req0_ready, req1_ready);
                end
            end
            if (k >= 3 && k <= 7) begin
                n_vec++;
                if (core_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_core_valid k=%0d got %b want 0", k, core_valid);
                end
            end
            if (rsp0_valid || rsp1_valid) pulses.push_back(k);
        end
        n_vec++;
        if (pulses.size() != 2 || pulses[0] != LAT + 2 || pulses[1] != LAT + 3) begin
            n_err++;
            $display("FAIL hold_drain got %0d pulses, first at %0d, want 2 at %0d", pulses.size(),
                     (pulses.size() > 0) ? pulses[0] : -1, LAT + 2);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int k = 0; k < 47; k++) begin
            @(posedge clk); #1;
            req0_valid = (k < 4 || k == 45); req1_valid = (k < 4 || k == 45);
            req0_state = rnd128(); req0_key = rnd128(); req1_state = rnd128(); req1_key = rnd128();
            rst = (k == 13);
            if (k == 13) begin
                #1;
                n_vec++;
                if (inflight !== 8'd0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_immediate got infl=%0d rsp=%b%b want 0 00", inflight, rsp0_valid, rsp1_valid);
                end
            end
            @(negedge clk);
            if (k == 12) begin
                n_vec++;
                if (inflight !== 8'd4) begin
                    n_err++;
                    $display("FAIL rstmid_preload got infl=%0d want 4", inflight);
                end
            end
            if (k >= 14 && k < 44) begin
                n_vec++;
                if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_stale k=%0d got rsp=%b%b want 00", k, rsp0_valid, rsp1_valid);
                end
            end
            if (k == 45) begin
                n_vec++;
                if ({req0_ready, req1_ready} !== 2'b10) begin
                    n_err++;
                    $display("FAIL rstmid_first_grant got %b%b want 10", req0_ready, req1_ready);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 330; k++) begin
            @(posedge clk); #1;
            req0_valid = (k < 300) && ($urandom_range(0, 3) != 0);
            req1_valid = (k < 300) && ($urandom_range(0, 3) != 0);
            hold       = ($urandom_range(0, 7) == 0);
            req0_state = rnd128(); req0_key = rnd128(); req1_state = rnd128(); req1_key = rnd128();
            @(negedge clk);
            n_vec++;
            if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) ||
                (req1_ready && !req1_valid) || (hold && (req0_ready || req1_ready))) begin
                n_err++;
                $display("FAIL random_ready k=%0d got %b%b with valid=%b%b hold=%b",
                         k, req0_ready, req1_ready, req0_valid, req1_valid, hold);
            end
        end
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_state = '0; req0_key = '0; req1_state = '0; req1_key = '0;
        #1 rst = 1'b1;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_hold();
        test_reset_midflight();
        test_random();
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
